// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
// Bundles the two requester ports and the SRAM macro port of the unified
// instruction/data SRAM arbiter.
//   slave  : the arbiter side. Takes requests and sram_rdata. Drives grants,
//            responses and the SRAM command.
//   master : the surrounding system (fetch unit, memory stage, SRAM macro).
// Signals
//   inst_req/inst_addr                      -> instruction read request
//   inst_gnt/inst_rvalid/inst_rdata         <- instruction grant and response
//   data_req/data_wen/data_addr/data_wdata  -> data request (wen==0 is a read)
//   data_gnt/data_rvalid/data_rdata         <- data grant and response
//   sram_en/sram_wen/sram_addr/sram_wdata   <- SRAM command
//   sram_rdata                              -> SRAM read data (1 cycle latency)
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_gnt;
    logic              inst_rvalid;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic [BE_W-1:0]   data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;

    logic              sram_en;
    logic [BE_W-1:0]   sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wen, data_addr, data_wdata,
        input  sram_rdata,
        output inst_gnt, inst_rvalid, inst_rdata,
        output data_gnt, data_rvalid, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wen, data_addr, data_wdata,
        output sram_rdata,
        input  inst_gnt, inst_rvalid, inst_rdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
// Shares one single-port synchronous SRAM between the instruction fetch
// requester and the data (memory stage) requester. At most one access is
// granted per cycle, and data has priority. An anti-starvation counter forces
// the instruction side through after STARVE_MAX consecutive data grants taken
// while an instruction request was waiting. The single outstanding read is
// tracked so that its rvalid goes back to the requester that owns it.
//
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous reset, active-high
//   bus    : sram_port_arbiter_if.slave (requesters + SRAM macro)
//   perf_inst_cnt / perf_data_cnt / perf_conflict_cnt : CNT_W counters,
//            present only when SRAM_ARB_PERF_EN is defined
//
// Configuration macro
//   SRAM_ARB_PERF_EN : adds the grant/conflict performance counters
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
`ifdef SRAM_ARB_PERF_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                clk,
    input  logic                reset,
    sram_port_arbiter_if.slave  bus
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]    perf_inst_cnt,
    output logic [CNT_W-1:0]    perf_data_cnt,
    output logic [CNT_W-1:0]    perf_conflict_cnt
`endif
);
    localparam int BE_W = DATA_W / 8;
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INST_RD = 2'd1,
        ST_DATA_RD = 2'd2
    } rd_state_e;

    rd_state_e         state_r;
    rd_state_e         state_next_s;
    logic [SC_W-1:0]   starve_cnt_r;
    logic              force_inst_s;
    logic              inst_gnt_s;
    logic              data_gnt_s;
    logic              data_rd_s;
    logic [ADDR_W-1:0] sram_addr_s;
    logic [DATA_W-1:0] sram_wdata_s;
    logic [BE_W-1:0]   sram_wen_s;

    // Grant decision: data first, unless the instruction side has starved.
    // Grants are held low throughout reset.
    always_comb begin
        force_inst_s = (starve_cnt_r == STARVE_LIM);
        if (reset) begin
            data_gnt_s = 1'b0;
            inst_gnt_s = 1'b0;
        end else begin
            data_gnt_s = bus.data_req & ~force_inst_s;
            inst_gnt_s = bus.inst_req & (~bus.data_req | force_inst_s);
        end
        data_rd_s = data_gnt_s & (bus.data_wen == {BE_W{1'b0}});
    end

    // SRAM command mux. With no grant the data side address/wdata stay on the bus.
    always_comb begin
        sram_wdata_s = bus.data_wdata;
        if (inst_gnt_s) begin
            sram_addr_s = bus.inst_addr;
            sram_wen_s  = {BE_W{1'b0}};
        end else if (data_gnt_s) begin
            sram_addr_s = bus.data_addr;
            sram_wen_s  = bus.data_wen;
        end else begin
            sram_addr_s = bus.data_addr;
            sram_wen_s  = {BE_W{1'b0}};
        end
        bus.sram_en    = inst_gnt_s | data_gnt_s;
        bus.sram_wen   = sram_wen_s;
        bus.sram_addr  = sram_addr_s;
        bus.sram_wdata = sram_wdata_s;
        bus.inst_gnt   = inst_gnt_s;
        bus.data_gnt   = data_gnt_s;
    end

    // Read-owner state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next read owner depends only on this cycle's grant; writes leave no owner
    always_comb begin
        if (inst_gnt_s) begin
            state_next_s = ST_INST_RD;
        end else if (data_rd_s) begin
            state_next_s = ST_DATA_RD;
        end else begin
            state_next_s = ST_IDLE;
        end
    end

    // Response steering: rvalid follows the owner, rdata is shared and must be qualified
    always_comb begin
        bus.inst_rdata = bus.sram_rdata;
        bus.data_rdata = bus.sram_rdata;
        case (state_r)
            ST_INST_RD: begin
                bus.inst_rvalid = 1'b1;
                bus.data_rvalid = 1'b0;
            end
            ST_DATA_RD: begin
                bus.inst_rvalid = 1'b0;
                bus.data_rvalid = 1'b1;
            end
            default: begin
                bus.inst_rvalid = 1'b0;
                bus.data_rvalid = 1'b0;
            end
        endcase
    end

    // Anti-starvation counter: counts data grants that bypass a waiting inst request, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else if (inst_gnt_s | ~bus.inst_req) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else if (data_gnt_s & (starve_cnt_r != STARVE_LIM)) begin
            starve_cnt_r <= starve_cnt_r + SC_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

`ifdef SRAM_ARB_PERF_EN
    logic [CNT_W-1:0] perf_inst_r;
    logic [CNT_W-1:0] perf_data_r;
    logic [CNT_W-1:0] perf_conflict_r;

    // Performance counters; they wrap modulo 2^CNT_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_inst_r     <= {CNT_W{1'b0}};
            perf_data_r     <= {CNT_W{1'b0}};
            perf_conflict_r <= {CNT_W{1'b0}};
        end else begin
            perf_inst_r     <= perf_inst_r + (inst_gnt_s ? CNT_W'(1) : CNT_W'(0));
            perf_data_r     <= perf_data_r + (data_gnt_s ? CNT_W'(1) : CNT_W'(0));
            perf_conflict_r <= perf_conflict_r +
                               ((bus.inst_req & bus.data_req) ? CNT_W'(1) : CNT_W'(0));
        end
    end

    assign perf_inst_cnt     = perf_inst_r;
    assign perf_data_cnt     = perf_data_r;
    assign perf_conflict_cnt = perf_conflict_r;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
// Directed scenarios followed by randomized traffic. A reference model works
// at the transaction level: who wins this cycle, how many data grants in a
// row have bypassed a waiting fetch, and which read response is due next.
// It keeps its own copy of memory that is updated from the transactions it
// expects. A simple SRAM macro model answers the DUT's sram_* commands.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perf_inst_cnt;
    logic [31:0] perf_data_cnt;
    logic [31:0] perf_conflict_cnt;
`endif

    sram_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef SRAM_ARB_PERF_EN
        ,
        .perf_inst_cnt(perf_inst_cnt),
        .perf_data_cnt(perf_data_cnt),
        .perf_conflict_cnt(perf_conflict_cnt)
`endif
    );

    // requester intent
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    // memories: macro model (driven by the DUT's commands) and reference copy
    logic [31:0] sram_mem [64];
    logic [31:0] ref_mem  [64];

    // reference model state
    int          starve_seen;
    bit          exp_irv;
    bit          exp_drv;
    logic [31:0] exp_rdata;
    longint      n_ig;
    longint      n_dg;
    longint      n_conf;

    // last-step observations for the directed scenarios
    bit          obs_ig;
    bit          obs_dg;
    bit          obs_irv;
    bit          obs_drv;
    logic [31:0] obs_irdata;
    logic [31:0] obs_drdata;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        bus.inst_req   = i_req;
        bus.inst_addr  = i_addr;
        bus.data_req   = d_req;
        bus.data_wen   = d_wen;
        bus.data_addr  = d_addr;
        bus.data_wdata = d_wdata;
    endtask

    // One clock cycle: predict, compare at the falling edge, advance the model and the SRAM.
    task automatic step();
        bit          e_ig;
        bit          e_dg;
        bit          starved;
        bit          s_en;
        logic [3:0]  s_wen;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        drive();
        @(negedge clk);
        if (reset) begin
            e_ig    = 1'b0;
            e_dg    = 1'b0;
            exp_irv = 1'b0;
            exp_drv = 1'b0;
        end else begin
            starved = (starve_seen >= STARVE_MAX);
            e_dg    = d_req && !starved;
            e_ig    = i_req && (!d_req || starved);
        end
        obs_ig     = bus.inst_gnt;
        obs_dg     = bus.data_gnt;
        obs_irv    = bus.inst_rvalid;
        obs_drv    = bus.data_rvalid;
        obs_irdata = bus.inst_rdata;
        obs_drdata = bus.data_rdata;
        chk("inst_gnt", bus.inst_gnt, e_ig);
        chk("data_gnt", bus.data_gnt, e_dg);
        chk("sram_en", bus.sram_en, e_ig | e_dg);
        chk("sram_wen", bus.sram_wen, e_dg ? d_wen : 4'h0);
        if (e_ig) chk("sram_addr_inst", bus.sram_addr, i_addr);
        else      chk("sram_addr_data", bus.sram_addr, d_addr);
        if (!e_ig) chk("sram_wdata", bus.sram_wdata, d_wdata);
        chk("inst_rvalid", bus.inst_rvalid, exp_irv);
        chk("data_rvalid", bus.data_rvalid, exp_drv);
        if (exp_irv) chk("inst_rdata", bus.inst_rdata, exp_rdata);
        if (exp_drv) chk("data_rdata", bus.data_rdata, exp_rdata);
        s_en    = bus.sram_en;
        s_wen   = bus.sram_wen;
        s_addr  = bus.sram_addr;
        s_wdata = bus.sram_wdata;

        if (reset) begin
            starve_seen = 0;
            n_ig = 0;
            n_dg = 0;
            n_conf = 0;
        end else begin
            if (i_req && d_req) n_conf++;
            exp_irv = e_ig;
            exp_drv = e_dg && (d_wen == 4'h0);
            if (e_ig) begin
                exp_rdata = ref_mem[i_addr[7:2]];
                n_ig++;
            end else if (e_dg) begin
                n_dg++;
                if (d_wen == 4'h0) exp_rdata = ref_mem[d_addr[7:2]];
                else ref_mem[d_addr[7:2]] = merge_bytes(ref_mem[d_addr[7:2]], d_wdata, d_wen);
            end
            if (e_ig || !i_req) starve_seen = 0;
            else if (e_dg && starve_seen < STARVE_MAX) starve_seen++;
        end

        @(posedge clk);
        #1;
        if (s_en) begin
            if (s_wen == 4'h0) bus.sram_rdata = sram_mem[s_addr[7:2]];
            else sram_mem[s_addr[7:2]] = merge_bytes(sram_mem[s_addr[7:2]], s_wdata, s_wen);
        end
        if (!reset && obs_ig) i_req = 1'b0;
        if (!reset && obs_dg) d_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            i_req = 1'b0;
            d_req = 1'b0;
            step();
        end
    endtask

    initial begin
        int dg_cnt;
        int ig_cnt;
        int run;
        int max_run;
        logic [31:0] w;

        for (int k = 0; k < 64; k++) begin
            w = $urandom;
            sram_mem[k] = w;
            ref_mem[k]  = w;
        end
        bus.sram_rdata = 32'h0;
        starve_seen = 0;
        exp_irv = 1'b0;
        exp_drv = 1'b0;
        exp_rdata = 32'h0;
        n_ig = 0;
        n_dg = 0;
        n_conf = 0;

        // 1: reset with both requests high, then release
        reset   = 1'b1;
        i_req   = 1'b1;
        i_addr  = 32'hBFC0_0000;
        d_req   = 1'b1;
        d_wen   = 4'h0;
        d_addr  = 32'h0000_0100;
        d_wdata = 32'h0;
        step();
        step();
        chk("t1_rst_inst_gnt", obs_ig, 1'b0);
        chk("t1_rst_data_gnt", obs_dg, 1'b0);
        reset = 1'b0;
        step();
        chk("t1_release_data_gnt", obs_dg, 1'b1);
        chk("t1_release_inst_gnt", obs_ig, 1'b0);
        d_req = 1'b0;
        step();
        idle(2);

        // 2: instruction-only read
        sram_mem[0] = 32'h3C1D_0001;
        ref_mem[0]  = 32'h3C1D_0001;
        i_req  = 1'b1;
        i_addr = 32'hBFC0_0000;
        step();
        chk("t2_inst_gnt", obs_ig, 1'b1);
        step();
        chk("t2_inst_rvalid", obs_irv, 1'b1);
        chk("t2_inst_rdata", obs_irdata, 32'h3C1D_0001);
        idle(1);

        // 3: conflict, data read wins then inst
        i_req  = 1'b1;
        d_req  = 1'b1;
        d_wen  = 4'h0;
        d_addr = 32'h0000_0100;
        step();
        chk("t3_c0_data_gnt", obs_dg, 1'b1);
        chk("t3_c0_inst_gnt", obs_ig, 1'b0);
        step();
        chk("t3_c1_data_rvalid", obs_drv, 1'b1);
        chk("t3_c1_data_rdata", obs_drdata, 32'h3C1D_0001);
        chk("t3_c1_inst_gnt", obs_ig, 1'b1);
        step();
        chk("t3_c2_inst_rvalid", obs_irv, 1'b1);
        idle(1);

        // 4: starvation bound with both requesters always asking
        dg_cnt = 0;
        ig_cnt = 0;
        run = 0;
        max_run = 0;
        for (int c = 0; c < 10; c++) begin
            i_req  = 1'b1;
            d_req  = 1'b1;
            d_wen  = 4'h0;
            d_addr = $urandom;
            step();
            if (obs_dg) begin
                dg_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end
            if (obs_ig) begin
                ig_cnt++;
                run = 0;
            end
        end
        chk("t4_data_grants", dg_cnt, 8);
        chk("t4_inst_grants", ig_cnt, 2);
        chk("t4_max_consecutive", max_run, STARVE_MAX);
        idle(2);

        // 5: partial write then read back
        sram_mem[8] = 32'h1122_3344;
        ref_mem[8]  = 32'h1122_3344;
        d_req   = 1'b1;
        d_wen   = 4'b0011;
        d_addr  = 32'h0000_0020;
        d_wdata = 32'hAABB_CCDD;
        step();
        chk("t5_write_gnt", obs_dg, 1'b1);
        d_req = 1'b1;
        d_wen = 4'h0;
        step();
        chk("t5_no_rvalid_after_write", obs_drv, 1'b0);
        chk("t5_read_gnt", obs_dg, 1'b1);
        step();
        chk("t5_read_rvalid", obs_drv, 1'b1);
        chk("t5_merged_rdata", obs_drdata, 32'h1122_CCDD);
        idle(1);

        // 6: reset while an instruction read is pending
        i_req  = 1'b1;
        i_addr = 32'hBFC0_0000;
        step();
        chk("t6_inst_gnt", obs_ig, 1'b1);
        reset = 1'b1;
        i_req = 1'b0;
        step();
        chk("t6_rvalid_dropped", obs_irv, 1'b0);
`ifdef SRAM_ARB_PERF_EN
        chk("t6_perf_inst", perf_inst_cnt, 32'h0);
        chk("t6_perf_data", perf_data_cnt, 32'h0);
        chk("t6_perf_conflict", perf_conflict_cnt, 32'h0);
`endif
        reset = 1'b0;
        step();
        chk("t6_rvalid_after_release", obs_irv, 1'b0);

        // randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            if (!i_req && $urandom_range(0, 3) != 0) begin
                i_req  = 1'b1;
                i_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 3) != 0) begin
                d_req   = 1'b1;
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            step();
        end
        idle(2);
`ifdef SRAM_ARB_PERF_EN
        chk("perf_inst_cnt", perf_inst_cnt, 32'(n_ig));
        chk("perf_data_cnt", perf_data_cnt, 32'(n_dg));
        chk("perf_conflict_cnt", perf_conflict_cnt, 32'(n_conf));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
